// File: rtl/serial_to_parallel_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel deserialiser.
package serial_to_parallel_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } s2p_state_e;

  // Counter width for a word of `width` bits; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_to_parallel_bit_counter.sv
// Modulo-WIDTH bit counter; clr beats inc, wrap flags the increment that rolls over.
// Registered count, wrap is same-cycle from count and inc; no backpressure.
module bit_counter
  import serial_to_parallel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] MAX = CW'(WIDTH - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      if (count_q == MAX) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/serial_to_parallel.sv
// Assembles WIDTH serial bits into a word; word visible the cycle after its last bit.
// No stall on input: an unacked word is overwritten by the next one and overrun sticks.
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     clear,
  input  logic                     word_ack,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     overrun
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             overrun_q, overrun_d;
  s2p_state_e       state_q, state_d;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    count;
  logic             wrap;

  bit_counter #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_bit_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (bit_valid),
    .clr  (clear),
    .count(count),
    .wrap (wrap)
  );

  always_comb begin
    shift_d   = shift_q;
    word_d    = word_q;
    overrun_d = overrun_q;
    state_d   = state_q;

    if (MSB_FIRST != 0) begin
      shifted = {shift_q[WIDTH-2:0], bit_in};
    end else begin
      shifted = {bit_in, shift_q[WIDTH-1:1]};
    end

    if (clear) begin
      shift_d = '0;
    end else if (bit_valid) begin
      shift_d = shifted;
    end

    // wrap already excludes clear, so the completing bit is always included.
    if (wrap) begin
      word_d = shifted;
    end

    case (state_q)
      EMPTY: begin
        if (wrap) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (wrap) begin
          if (!word_ack) begin
            overrun_d = 1'b1;
          end
        end else if (word_ack) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      word_q    <= '0;
      overrun_q <= 1'b0;
      state_q   <= EMPTY;
    end else begin
      shift_q   <= shift_d;
      word_q    <= word_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = (state_q == FULL);
  assign bit_count  = count;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench: MSB-first and LSB-first instances share one serial stream.
module tb_serial_to_parallel;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       clear;
  logic       word_ack;

  logic [7:0] m_word, l_word;
  logic       m_vld, l_vld;
  logic [2:0] m_cnt, l_cnt;
  logic       m_ovr, l_ovr;

  int total = 0;
  int bad   = 0;
  int vld_cycles = 0;

  logic [7:0] m_exp_q[$];
  logic [7:0] l_exp_q[$];

  always #5 clk = ~clk;

  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .word_ack(word_ack), .word_out(m_word),
    .word_valid(m_vld), .bit_count(m_cnt), .overrun(m_ovr)
  );

  serial_to_parallel #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear(clear), .word_ack(word_ack), .word_out(l_word),
    .word_valid(l_vld), .bit_count(l_cnt), .overrun(l_ovr)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bits of w go out MSB first; optionally ack on the cycle of the final bit.
  task automatic send_word(input logic [7:0] w, input bit ack_last);
    for (int i = 7; i >= 0; i--) begin
      bit_in    = w[i];
      bit_valid = 1'b1;
      if (i == 0 && ack_last) word_ack = 1'b1;
      step();
    end
    bit_valid = 1'b0;
    if (ack_last) word_ack = 1'b0;
  endtask

  task automatic push(input logic [7:0] m_exp, input logic [7:0] l_exp);
    m_exp_q.push_back(m_exp);
    l_exp_q.push_back(l_exp);
  endtask

  // A new word is presented when valid rises, follows an ack, or changes in place.
  logic       m_pv = 1'b0, l_pv = 1'b0, p_ack = 1'b0;
  logic [7:0] m_pw = '0, l_pw = '0;

  always @(negedge clk) begin
    if (m_vld === 1'b1) vld_cycles++;
    if (m_vld === 1'b1 && (!m_pv || p_ack || m_word !== m_pw)) begin
      if (m_exp_q.size() == 0) chk("msb_unexpected_word", {24'h0, m_word}, 32'hdead);
      else chk("msb_word", {24'h0, m_word}, {24'h0, m_exp_q.pop_front()});
    end
    if (l_vld === 1'b1 && (!l_pv || p_ack || l_word !== l_pw)) begin
      if (l_exp_q.size() == 0) chk("lsb_unexpected_word", {24'h0, l_word}, 32'hdead);
      else chk("lsb_word", {24'h0, l_word}, {24'h0, l_exp_q.pop_front()});
    end
    m_pv  = (m_vld === 1'b1);
    l_pv  = (l_vld === 1'b1);
    m_pw  = m_word;
    l_pw  = l_word;
    p_ack = (word_ack === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0; word_ack = 1'b0;

    // Reset held while every input toggles.
    for (int c = 0; c < 6; c++) begin
      bit_in    = 1'($urandom_range(1));
      bit_valid = 1'($urandom_range(1));
      clear     = 1'($urandom_range(1));
      word_ack  = 1'($urandom_range(1));
      step();
      chk("rst_word", {24'h0, m_word}, 32'h0);
      chk("rst_vld", {31'h0, m_vld}, 32'h0);
      chk("rst_cnt", {29'h0, m_cnt}, 32'h0);
      chk("rst_ovr", {31'h0, m_ovr | l_ovr}, 32'h0);
    end
    bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0; word_ack = 1'b0;
    reset = 1'b0;
    step();
    chk("idle_vld", {30'h0, m_vld, l_vld}, 32'h0);

    // 1,0,1,0,0,1,1,0 -> 0xA6 MSB-first, 0x65 LSB-first.
    push(8'hA6, 8'h65);
    send_word(8'hA6, 1'b0);
    chk("a6_vld", {30'h0, m_vld, l_vld}, 32'h3);
    chk("a6_cnt", {29'h0, m_cnt}, 32'h0);
    word_ack = 1'b1; step(); word_ack = 1'b0;
    chk("a6_ack_clears", {30'h0, m_vld, l_vld}, 32'h0);

    // Three bits, then clear together with a fourth bit.
    for (int i = 0; i < 3; i++) begin
      bit_in = ~bit_in; bit_valid = 1'b1; step();
    end
    chk("partial_cnt", {29'h0, m_cnt}, 32'h3);
    bit_in = 1'b1; clear = 1'b1; step();
    clear = 1'b0; bit_valid = 1'b0;
    chk("clear_cnt", {26'h0, m_cnt, l_cnt}, 32'h0);
    chk("clear_keeps_vld", {30'h0, m_vld, l_vld}, 32'h0);
    push(8'hFF, 8'hFF);
    send_word(8'hFF, 1'b0);
    word_ack = 1'b1; step(); word_ack = 1'b0;

    // Unacked 0x12 overwritten by 0x34.
    push(8'h12, 8'h48);
    send_word(8'h12, 1'b0);
    chk("pre_ovr", {30'h0, m_ovr, l_ovr}, 32'h0);
    push(8'h34, 8'h2C);
    send_word(8'h34, 1'b0);
    chk("ovr_set", {30'h0, m_ovr, l_ovr}, 32'h3);
    chk("ovr_vld", {31'h0, m_vld}, 32'h1);
    word_ack = 1'b1; step(); word_ack = 1'b0;
    repeat (3) step();
    chk("ovr_sticky", {30'h0, m_ovr, l_ovr}, 32'h3);

    reset = 1'b1; step(); reset = 1'b0;
    chk("ovr_reset", {30'h0, m_ovr, l_ovr}, 32'h0);

    // Same pair, but acked on the completing edge of 0x34.
    push(8'h12, 8'h48);
    send_word(8'h12, 1'b0);
    push(8'h34, 8'h2C);
    send_word(8'h34, 1'b1);
    chk("ack_cmp_ovr", {30'h0, m_ovr, l_ovr}, 32'h0);
    chk("ack_cmp_vld", {30'h0, m_vld, l_vld}, 32'h3);
    word_ack = 1'b1; step(); word_ack = 1'b0;
    chk("ack_cmp_clear", {30'h0, m_vld, l_vld}, 32'h0);

    // Back-to-back words with ack held high.
    word_ack = 1'b1;
    vld_cycles = 0;
    push(8'hC3, 8'hC3);
    push(8'h5A, 8'h5A);
    send_word(8'hC3, 1'b0);
    send_word(8'h5A, 1'b0);
    repeat (4) step();
    word_ack = 1'b0;
    chk("stream_vld_cycles", vld_cycles, 32'd2);
    chk("stream_ovr", {30'h0, m_ovr, l_ovr}, 32'h0);

    repeat (2) step();
    chk("msb_queue_drained", m_exp_q.size(), 32'd0);
    chk("lsb_queue_drained", l_exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
